gmii_rx_fcs_check: RTL and testbench

Receive-side GMII front end, between the PHY pins (e_rxc/e_rxdv/e_rxer/e_rxd) and the UDP receive parser. It strips preamble/SFD, checks the Ethernet FCS (CRC-32), and removes the 4 FCS bytes through a delay line. It emits a clean payload byte stream with start marker and end-of-frame status, so the parser consumes only destination-MAC-onward bytes and can discard bad frames.

---
 rtl/gmii_rx_fcs_check.sv | 151 +++++++++++++++
 tb/tb_gmii_rx_fcs_check.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive front end: strips preamble/SFD, checks the Ethernet FCS and
// removes the 4 FCS bytes through a delay line, reporting status per frame.
module gmii_rx_fcs_check #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1514
) (
    input  logic        e_rxc,
    input  logic        reset_n,
    input  logic        gmii_rxdv,
    input  logic        gmii_rxer,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_dv,
    output logic [7:0]  rx_d,
    output logic        rx_sof,
    output logic        rx_done,
    output logic        rx_ok,
    output logic [2:0]  rx_err,
    output logic [10:0] rx_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned LEN_W   = 11;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t             state;
    logic               rxdv_r, rxer_r, pin_vld;
    logic [7:0]         rxd_r;
    logic [31:0]        crc;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   emit_cnt;
    logic [2:0]         err;
    logic [3:0][7:0]    dly;
    logic               first;
    logic [2:0]         done_err;

    // Reflected CRC-32, LSB first, no final inversion (residue check).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        done_err    = err;
        done_err[0] = (crc != CRC_RESIDUE);
        done_err[2] = err[2] | (emit_cnt < LEN_W'(MIN_LEN));
    end

    always_ff @(posedge e_rxc) begin
        if (!reset_n) begin
            state    <= WAIT_IDLE;
            rxdv_r   <= 1'b0;
            rxer_r   <= 1'b0;
            rxd_r    <= 8'd0;
            pin_vld  <= 1'b0;
            crc      <= 32'hFFFFFFFF;
            cnt      <= '0;
            emit_cnt <= '0;
            err      <= 3'd0;
            dly      <= '0;
            first    <= 1'b0;
            rx_dv    <= 1'b0;
            rx_d     <= 8'd0;
            rx_sof   <= 1'b0;
            rx_done  <= 1'b0;
            rx_ok    <= 1'b0;
            rx_err   <= 3'd0;
            rx_len   <= '0;
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else begin
            rxdv_r  <= gmii_rxdv;
            rxer_r  <= gmii_rxer;
            rxd_r   <= gmii_rxd;
            pin_vld <= 1'b1;
            rx_dv   <= 1'b0;
            rx_sof  <= 1'b0;
            rx_done <= 1'b0;
            rx_ok   <= 1'b0;
            rx_err  <= 3'd0;
            rx_len  <= '0;

            // Counters follow the registered done strobe, one cycle later.
            if (rx_done) begin
                if (rx_ok) good_cnt <= good_cnt + 16'd1;
                else       bad_cnt  <= bad_cnt + 16'd1;
            end

            case (state)
                // pin_vld keeps the reset value of rxdv_r from counting as idle.
                WAIT_IDLE: if (pin_vld && !rxdv_r) state <= IDLE;
                IDLE: begin
                    if (rxdv_r) state <= (rxd_r == 8'h55) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (!rxdv_r) begin
                        state <= IDLE;
                    end else if (rxd_r == 8'hD5) begin
                        state    <= DATA;
                        crc      <= 32'hFFFFFFFF;
                        cnt      <= '0;
                        emit_cnt <= '0;
                        err      <= 3'd0;
                        dly      <= '0;
                        first    <= 1'b1;
                    end else if (rxd_r != 8'h55) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (rxdv_r) begin
                        crc <= crc_byte(crc, rxd_r);
                        dly <= {dly[2:0], rxd_r};
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                        if (rxer_r) err[1] <= 1'b1;
                        // Delay line full: the oldest byte leaves as payload.
                        if (cnt >= CNT_W'(4)) begin
                            if (emit_cnt < LEN_W'(MAX_LEN)) begin
                                rx_dv    <= 1'b1;
                                rx_d     <= dly[3];
                                rx_sof   <= first;
                                first    <= 1'b0;
                                emit_cnt <= emit_cnt + LEN_W'(1);
                            end else begin
                                err[2] <= 1'b1;
                            end
                        end
                    end else begin
                        state   <= IDLE;
                        rx_done <= 1'b1;
                        rx_err  <= done_err;
                        rx_ok   <= (done_err == 3'd0);
                        rx_len  <= emit_cnt;
                    end
                end
                DROP:    if (!rxdv_r) state <= IDLE;
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check: builds frames with a golden CRC,
// captures the payload stream and checks data, timing and status.
module tb_gmii_rx_fcs_check;

    logic        e_rxc = 1'b0;
    logic        reset_n = 1'b0;
    logic        gmii_rxdv = 1'b0;
    logic        gmii_rxer = 1'b0;
    logic [7:0]  gmii_rxd = 8'd0;
    logic        rx_dv, rx_sof, rx_done, rx_ok;
    logic [7:0]  rx_d;
    logic [2:0]  rx_err;
    logic [10:0] rx_len;
    logic [15:0] good_cnt, bad_cnt;

    gmii_rx_fcs_check #(.MIN_LEN(60), .MAX_LEN(1514)) dut (
        .e_rxc(e_rxc), .reset_n(reset_n), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
        .gmii_rxd(gmii_rxd), .rx_dv(rx_dv), .rx_d(rx_d), .rx_sof(rx_sof), .rx_done(rx_done),
        .rx_ok(rx_ok), .rx_err(rx_err), .rx_len(rx_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #4 e_rxc = ~e_rxc;

    int cyc = 0;
    always @(posedge e_rxc) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [7:0] rxq[$];
    int         last_dv_cyc = 0, sof_cnt = 0, sof_cyc = 0, done_cnt = 0, done_cyc = 0;
    int         overlap = 0, stray = 0;
    logic [7:0] sof_byte = 8'd0;
    logic       d_ok = 1'b0;
    logic [2:0] d_err = 3'd0;
    logic [10:0] d_len = 11'd0;

    always @(negedge e_rxc) begin
        if (rx_dv) begin
            rxq.push_back(rx_d);
            last_dv_cyc = cyc;
        end
        if (rx_sof) begin
            sof_cnt++;
            sof_cyc  = cyc;
            sof_byte = rx_d;
        end
        if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            d_ok  = rx_ok;
            d_err = rx_err;
            d_len = rx_len;
        end
        if (rx_dv && rx_done) overlap++;
        if (!rx_done && (rx_ok || rx_err != 3'd0 || rx_len != 11'd0)) stray++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [7:0] fb[$];
    logic       ef[$];
    logic [7:0] pl[$];

    task automatic build(input int n, input int er_idx, input bit bad_fcs, input bit bad_pre);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        fb.delete(); ef.delete(); pl.delete();
        for (int i = 0; i < 7; i++) begin
            fb.push_back((bad_pre && i == 3) ? 8'h5A : 8'h55);
            ef.push_back(1'b0);
        end
        fb.push_back(8'hD5); ef.push_back(1'b0);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            pl.push_back(b); fb.push_back(b); ef.push_back(i == er_idx);
            crc = crc_upd(crc, b);
        end
        fcs = ~crc;
        if (bad_fcs) fcs[31:24] = fcs[31:24] ^ 8'h01;
        for (int j = 0; j < 4; j++) begin
            fb.push_back(fcs[8*j +: 8]);
            ef.push_back(1'b0);
        end
    endtask

    // Drives fb, then one idle cycle. rst_at >= 0 pulses reset for 2 cycles.
    task automatic drive(input int rst_at, output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge e_rxc); #1;
            gmii_rxdv = 1'b1; gmii_rxd = fb[i]; gmii_rxer = ef[i];
            if (i == 8) first_cyc = cyc + 1;
            if (i == rst_at) reset_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 2) reset_n = 1'b1;
        end
        @(posedge e_rxc); #1;
        gmii_rxdv = 1'b0; gmii_rxer = 1'b0; gmii_rxd = 8'd0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 4000 && done_cnt < target; i++) @(posedge e_rxc);
        check(tag, 32'(done_cnt >= target), 32'd1);
        repeat (3) @(posedge e_rxc);
    endtask

    task automatic cmp_bytes(input int base, input string tag);
        int mism;
        mism = 0;
        check({tag, "_count"}, 32'(rxq.size() - base), 32'(pl.size()));
        for (int i = 0; i < pl.size() && base + i < rxq.size(); i++)
            if (rxq[base + i] !== pl[i]) mism++;
        check({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    int base, dbase, fc, fc2, mism;

    initial begin
        repeat (4) @(posedge e_rxc);
        @(negedge e_rxc);
        check("reset_outputs", {rx_dv, rx_sof, rx_done, rx_ok, rx_err, rx_len}, 32'd0);
        check("reset_counters", {good_cnt, bad_cnt}, 32'd0);
        @(posedge e_rxc); #1 reset_n = 1'b1;
        repeat (3) @(posedge e_rxc);

        // Good 60-byte frame
        base = rxq.size(); dbase = done_cnt;
        build(60, -1, 1'b0, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "good_done");
        cmp_bytes(base, "good");
        check("good_sof_byte", 32'(sof_byte), 32'h00);
        check("good_latency", 32'(sof_cyc - fc), 32'd5);
        check("good_done_timing", 32'(done_cyc - last_dv_cyc), 32'd1);
        check("good_status", {d_ok, d_err, d_len}, {17'd0, 1'b1, 3'b000, 11'd60});
        check("good_cnt1", 32'(good_cnt), 32'd1);

        // Corrupted last FCS byte
        base = rxq.size(); dbase = done_cnt;
        build(60, -1, 1'b1, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "badfcs_done");
        cmp_bytes(base, "badfcs");
        check("badfcs_status", {d_ok, d_err, d_len}, {17'd0, 1'b0, 3'b001, 11'd60});
        check("bad_cnt1", 32'(bad_cnt), 32'd1);

        // gmii_rxer on payload byte 20
        dbase = done_cnt;
        build(64, 20, 1'b0, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "rxer_done");
        check("rxer_status", {d_ok, d_err, d_len}, {17'd0, 1'b0, 3'b010, 11'd64});

        // Short 40-byte payload
        base = rxq.size(); dbase = done_cnt;
        build(40, -1, 1'b0, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "short_done");
        cmp_bytes(base, "short");
        check("short_status", {d_ok, d_err, d_len}, {17'd0, 1'b0, 3'b100, 11'd40});

        // Oversize 1600-byte payload truncated at 1514
        base = rxq.size(); dbase = done_cnt;
        build(1600, -1, 1'b0, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "long_done");
        check("long_dv_count", 32'(rxq.size() - base), 32'd1514);
        mism = 0;
        for (int i = 0; i < 1514 && base + i < rxq.size(); i++)
            if (rxq[base + i] !== pl[i]) mism++;
        check("long_bytes", 32'(mism), 32'd0);
        check("long_status", {d_ok, d_err, d_len}, {17'd0, 1'b0, 3'b100, 11'd1514});
        check("bad_cnt4", 32'(bad_cnt), 32'd4);

        // Two good frames with one idle cycle between
        base = rxq.size(); dbase = done_cnt;
        build(60, -1, 1'b0, 1'b0); drive(-1, fc); drive(-1, fc2);
        wait_done(dbase + 2, "b2b_done");
        check("b2b_dv_count", 32'(rxq.size() - base), 32'd120);
        check("b2b_sof_latency", 32'(sof_cyc - fc2), 32'd5);
        check("b2b_sof_byte", 32'(sof_byte), 32'h00);
        check("b2b_status", {d_ok, d_err, d_len}, {17'd0, 1'b1, 3'b000, 11'd60});
        check("good_cnt3", 32'(good_cnt), 32'd3);

        // Bad preamble byte: frame dropped silently
        base = rxq.size(); dbase = done_cnt;
        build(60, -1, 1'b0, 1'b1); drive(-1, fc);
        repeat (10) @(posedge e_rxc);
        check("badpre_no_output", {16'(rxq.size() - base), 16'(done_cnt - dbase)}, 32'd0);

        // Runt: 3 bytes after SFD
        base = rxq.size(); dbase = done_cnt;
        fb.delete(); ef.delete();
        for (int i = 0; i < 7; i++) begin fb.push_back(8'h55); ef.push_back(1'b0); end
        fb.push_back(8'hD5); ef.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin fb.push_back(8'hA0); ef.push_back(1'b0); end
        drive(-1, fc);
        wait_done(dbase + 1, "runt_done");
        check("runt_no_dv", 32'(rxq.size() - base), 32'd0);
        check("runt_status", {d_ok, d_err[2], d_len}, {19'd0, 1'b0, 1'b1, 11'd0});

        // Reset at payload byte 30, released while rxdv still high
        build(60, -1, 1'b0, 1'b0);
        fork
            drive(8 + 30, fc);
            begin
                wait (reset_n == 1'b0);
                @(posedge e_rxc); @(negedge e_rxc);
                check("rst_outputs", {rx_dv, rx_done, rx_ok, rx_err, rx_len}, 32'd0);
                check("rst_counters", {good_cnt, bad_cnt}, 32'd0);
                wait (reset_n == 1'b1);
                base = rxq.size(); dbase = done_cnt;
            end
        join
        repeat (10) @(posedge e_rxc);
        check("rst_no_output", {16'(rxq.size() - base), 16'(done_cnt - dbase)}, 32'd0);

        base = rxq.size(); dbase = done_cnt;
        build(60, -1, 1'b0, 1'b0); drive(-1, fc);
        wait_done(dbase + 1, "post_rst_done");
        cmp_bytes(base, "post_rst");
        check("post_rst_status", {d_ok, d_err, d_len}, {17'd0, 1'b1, 3'b000, 11'd60});
        check("post_rst_good", 32'(good_cnt), 32'd1);

        check("dv_done_overlap", 32'(overlap), 32'd0);
        check("status_outside_done", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
